// File: rtl/stack_program_sequencer.sv
// Instruction-issuing front end for the stack machine: program memory, depth
// tracking for underflow/overflow, and result/status reporting to the host.
module stack_program_sequencer #(
    parameter int N  = 8,
    parameter int S  = 8,
    parameter int P  = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [N+2:0]  prog_wdata,
    input  logic          start,
    input  logic [AW:0]   len,
    output logic [2:0]    e_out,
    output logic [N-1:0]  g_out,
    output logic          sm_rst,
    input  logic [N-1:0]  sm_o,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [AW-1:0] err_pc,
    output logic [N-1:0]  result,
    output logic [2:0]    dbg_state
);

    localparam int DW = $clog2(S + 1);
    localparam logic [AW:0]   P_MAX = (AW + 1)'(P);
    localparam logic [DW-1:0] S_MAX = DW'(S);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_MULT = 3'd3;
    localparam logic [2:0] OP_PUSH = 3'd4;
    localparam logic [2:0] OP_NEG  = 3'd5;
    localparam logic [2:0] OP_AND  = 3'd6;
    localparam logic [2:0] OP_OR   = 3'd7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        RUN    = 3'd2,
        FINISH = 3'd3,
        ERR    = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [N+2:0]  mem [0:P-1];
    logic [AW-1:0] pc;
    logic [AW:0]   len_q;
    logic [DW-1:0] depth;

    logic [N+2:0]  instr;
    logic [2:0]    op;
    logic [N-1:0]  operand;
    logic          is_push, is_unary, is_binary;
    logic          underflow, overflow, fault, last;

    assign instr     = mem[pc];
    assign op        = instr[N+2:N];
    assign operand   = instr[N-1:0];
    assign is_push   = (op == OP_PUSH);
    assign is_unary  = (op == OP_NEG);
    assign is_binary = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MULT) ||
                       (op == OP_AND) || (op == OP_OR);
    assign underflow = (is_binary && depth < DW'(2)) || (is_unary && depth < DW'(1));
    assign overflow  = is_push && (depth == S_MAX);
    assign fault     = underflow || overflow;
    assign last      = ({1'b0, pc} == len_q - 1'b1);

    assign busy      = (state == CLEAR) || (state == RUN) || (state == FINISH);
    assign sm_rst    = !rst_n || (state == CLEAR);
    assign dbg_state = state;

    always_comb begin
        state_nx = state;
        e_out    = OP_NOP;
        g_out    = '0;
        case (state)
            IDLE:    if (start) state_nx = (len > P_MAX) ? ERR : CLEAR;
            CLEAR:   state_nx = (len_q == '0) ? FINISH : RUN;
            RUN: begin
                g_out = is_push ? operand : '0;
                // A faulting instruction is never issued: the machine sees a nop.
                if (fault) begin
                    state_nx = ERR;
                end else begin
                    e_out = op;
                    if (last) state_nx = FINISH;
                end
            end
            FINISH:  state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Program memory has no reset; writes are locked out while a run is active.
    always_ff @(posedge clk) begin
        if (prog_we && !busy) mem[prog_addr] <= prog_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= '0;
            len_q    <= '0;
            depth    <= '0;
            result   <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
            err_pc   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        done <= 1'b0;
                        if (len > P_MAX) begin
                            err      <= 1'b1;
                            err_code <= 2'd3;
                            err_pc   <= '0;
                        end else begin
                            err   <= 1'b0;
                            len_q <= len;
                            depth <= '0;
                            pc    <= '0;
                        end
                    end
                end
                RUN: begin
                    if (fault) begin
                        err      <= 1'b1;
                        err_code <= overflow ? 2'd2 : 2'd1;
                        err_pc   <= pc;
                    end else begin
                        pc <= pc + 1'b1;
                        if (is_push)        depth <= depth + 1'b1;
                        else if (is_binary) depth <= depth - 1'b1;
                    end
                end
                FINISH: begin
                    result <= sm_o;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_program_sequencer.sv
// Bench for stack_program_sequencer: a behavioural stack machine drives sm_o,
// and a program-level model predicts every output cycle by cycle.
module tb_stack_program_sequencer;

    localparam int N  = 8;
    localparam int S  = 8;
    localparam int P  = 16;
    localparam int AW = 4;
    localparam int W  = 29;

    localparam logic [2:0] NOP = 3'd0, ADD = 3'd1, SUB = 3'd2, MUL = 3'd3;
    localparam logic [2:0] PSH = 3'd4, NEG = 3'd5, AND = 3'd6, ORR = 3'd7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [N+2:0]  prog_wdata;
    logic          start;
    logic [AW:0]   len;
    logic [2:0]    e_out;
    logic [N-1:0]  g_out;
    logic          sm_rst;
    logic [N-1:0]  sm_o;
    logic          busy, done, err;
    logic [1:0]    err_code;
    logic [AW-1:0] err_pc;
    logic [N-1:0]  result;
    logic [2:0]    dbg_state;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];

    // program-level model state
    logic [N+2:0]  m_mem [0:P-1];
    logic [N-1:0]  m_result;
    logic          m_done, m_err;
    logic [1:0]    m_code;
    logic [AW-1:0] m_epc;

    stack_program_sequencer #(.N(N), .S(S), .P(P), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .start(start), .len(len), .e_out(e_out),
        .g_out(g_out), .sm_rst(sm_rst), .sm_o(sm_o), .busy(busy), .done(done),
        .err(err), .err_code(err_code), .err_pc(err_pc), .result(result),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] alu(input logic [2:0] op, input logic [N-1:0] a,
                                         input logic [N-1:0] b);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            MUL:     return N'(a * b);
            AND:     return a & b;
            ORR:     return a | b;
            default: return a;
        endcase
    endfunction

    // behavioural stack machine on the far side of e_out/g_out
    logic [N-1:0] stk [0:S-1];
    int sp = 0;
    always @(posedge clk) begin
        if (sm_rst) sp <= 0;
        else case (e_out)
            PSH: if (sp < S) begin stk[sp] <= g_out; sp <= sp + 1; end
            NEG: if (sp >= 1) stk[sp-1] <= N'(0 - stk[sp-1]);
            NOP: ;
            default: if (sp >= 2) begin
                stk[sp-2] <= alu(e_out, stk[sp-1], stk[sp-2]);
                sp <= sp - 1;
            end
        endcase
    end
    assign sm_o = (sp == 0) ? '0 : stk[sp-1];

    function automatic logic [W-1:0] ent(input logic s, input logic b, input logic [2:0] e,
                                         input logic [N-1:0] g);
        return {s, b, m_done, m_err, m_code, m_epc, e, g, m_result};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] want, got;
            want = exp_q.pop_front();
            got  = {sm_rst, busy, done, err, err_code, err_pc, e_out, g_out, result};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL trace @%0t: got %h want %h (rst,busy,done,err,code,pc,e,g,res)",
                         $time, got, want);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Expected outputs for every cycle after the start edge, from program semantics.
    task automatic build_trace(input int l);
        logic [N-1:0] sq[$];
        logic [2:0]   op;
        logic [N-1:0] opd, g, a, b;
        int           need;
        bit           fault = 0;
        if (l > P) begin
            m_done = 0; m_err = 1; m_code = 2'd3; m_epc = '0;
            exp_q.push_back(ent(0, 0, NOP, '0));
            exp_q.push_back(ent(0, 0, NOP, '0));
            return;
        end
        m_done = 0; m_err = 0;
        exp_q.push_back(ent(1, 1, NOP, '0));
        for (int pc = 0; pc < l; pc++) begin
            op   = m_mem[pc][N+2:N];
            opd  = m_mem[pc][N-1:0];
            g    = (op == PSH) ? opd : '0;
            need = (op == NEG) ? 1 : (op == NOP || op == PSH) ? 0 : 2;
            if (sq.size() < need || (op == PSH && sq.size() == S)) begin
                exp_q.push_back(ent(0, 1, NOP, g));
                m_err = 1; m_code = (op == PSH) ? 2'd2 : 2'd1; m_epc = AW'(pc);
                fault = 1;
                break;
            end
            exp_q.push_back(ent(0, 1, op, g));
            if (op == PSH) sq.push_back(opd);
            else if (op == NEG) begin a = sq.pop_back(); sq.push_back(N'(0 - a)); end
            else if (op != NOP) begin
                a = sq.pop_back(); b = sq.pop_back(); sq.push_back(alu(op, a, b));
            end
        end
        if (fault) begin
            exp_q.push_back(ent(0, 0, NOP, '0));
            exp_q.push_back(ent(0, 0, NOP, '0));
        end else begin
            exp_q.push_back(ent(0, 1, NOP, '0));
            m_result = (sq.size() == 0) ? '0 : sq[$];
            m_done = 1;
            exp_q.push_back(ent(0, 0, NOP, '0));
        end
    endtask

    task automatic load(input int addr, input logic [2:0] op, input logic [N-1:0] opd);
        @(posedge clk); #1;
        prog_we = 1; prog_addr = AW'(addr); prog_wdata = {op, opd};
        @(posedge clk); #1;
        prog_we = 0;
        m_mem[addr] = {op, opd};
    endtask

    task automatic start_run(input int l);
        @(posedge clk); #1;
        start = 1; len = (AW + 1)'(l);
        @(posedge clk); #1;
        start = 0; len = '0;
        build_trace(l);
    endtask

    task automatic wait_run();
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("run_timeout", 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; prog_we = 0; prog_addr = '0; prog_wdata = '0; start = 0; len = '0;
        m_result = '0; m_done = 0; m_err = 0; m_code = '0; m_epc = '0;
        for (int i = 0; i < P; i++) m_mem[i] = '0;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(dbg_state), 0);
        check("rst_sm_rst", 32'(sm_rst), 1);
        check("rst_e_g", {e_out, g_out}, 0);
        check("rst_status", {busy, done, err, err_code, err_pc}, 0);
        check("rst_result", 32'(result), 0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        check("post_rst_sm_rst", 32'(sm_rst), 0);
        // Memory is not reset: fill every entry with nop so the model agrees.
        for (int i = 0; i < P; i++) load(i, NOP, '0);

        // push 3, push 5, add
        load(0, PSH, 8'd3); load(1, PSH, 8'd5); load(2, ADD, 8'd0);
        start_run(3); wait_run();
        check("add_result", 32'(result), 32'h08);
        check("add_model", 32'(m_result), 32'h08);

        load(2, SUB, 8'd0);
        start_run(3); wait_run();
        check("sub_result", 32'(result), 32'h02);

        load(0, PSH, 8'd20); load(1, PSH, 8'd20); load(2, MUL, 8'd0);
        start_run(3); wait_run();
        check("mult_result", 32'(result), 32'h90);

        // underflow: push 1, add
        load(0, PSH, 8'd1); load(1, ADD, 8'd0);
        start_run(2); wait_run();
        check("uflow_code_pc", {done, err, err_code, err_pc}, {1'b0, 1'b1, 2'd1, 4'd1});
        check("uflow_result_kept", 32'(result), 32'h90);

        // overflow: nine pushes
        for (int i = 0; i < 9; i++) load(i, PSH, 8'(i + 1));
        start_run(9); wait_run();
        check("oflow_code_pc", {err, err_code, err_pc}, {1'b1, 2'd2, 4'd8});

        // len beyond program memory
        start_run(17); wait_run();
        check("len_code_pc", {err, err_code, err_pc}, {1'b1, 2'd3, 4'd0});

        // empty program
        start_run(0); wait_run();
        check("len0_result", {done, err, result}, {1'b1, 1'b0, 8'h00});

        // push 15, neg, push 0x3c, and, push 1, or, nop
        load(0, PSH, 8'h0f); load(1, NEG, 8'd0); load(2, PSH, 8'h3c); load(3, AND, 8'd0);
        load(4, PSH, 8'h01); load(5, ORR, 8'd0); load(6, NOP, 8'd0);
        start_run(7); wait_run();
        check("logic_result", 32'(result), 32'h31);
        check("logic_model", 32'(m_result), 32'h31);

        // unary underflow at pc 0
        load(0, NEG, 8'd0);
        start_run(1); wait_run();
        check("neg_uflow", {err, err_code, err_pc}, {1'b1, 2'd1, 4'd0});

        // writes and start pulses during a run are ignored
        load(0, PSH, 8'd3); load(1, PSH, 8'd5); load(2, ADD, 8'd0);
        start_run(3);
        start = 1; len = '0; prog_we = 1; prog_addr = '0; prog_wdata = {PSH, 8'd99};
        @(posedge clk); #1;
        start = 0; prog_we = 0;
        wait_run();
        start_run(3); wait_run();
        check("locked_mem_result", 32'(result), 32'h08);

        // reset in the middle of a run: push 7, push 2, sub, push 4, mult
        load(0, PSH, 8'd7); load(1, PSH, 8'd2); load(2, SUB, 8'd0);
        load(3, PSH, 8'd4); load(4, MUL, 8'd0);
        start_run(5);
        repeat (3) @(negedge clk);
        exp_q.delete();
        #1 rst_n = 0;
        #1;
        check("midrst_state", 32'(dbg_state), 0);
        check("midrst_outs", {sm_rst, busy, e_out, g_out}, {1'b1, 1'b0, 3'd0, 8'd0});
        check("midrst_status", {done, err, err_code, err_pc, result}, 0);
        @(posedge clk); #1 rst_n = 1;
        m_result = '0; m_done = 0; m_err = 0; m_code = '0; m_epc = '0;
        start_run(5); wait_run();
        check("after_rst_result", 32'(result), 32'hec);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack_program_sequencer.md
Name: stack_program_sequencer

Overview:
- Instruction-issuing front end for the stack machine: holds a small program memory, then on `start` drives the machine's opcode and operand inputs one instruction per cycle.
- Tracks stack depth to catch underflow and overflow before issue, captures the final top-of-stack as `result`, and reports done or error to the host.
- Sits between the host/garbled-input loader and the stack machine; it is the producer end of the machine's `e_input` / `g_input` interface.

Parameters:
- N, 8, data width; matches the stack machine's N.
- S, 8, stack depth; matches the stack machine's S.
- P, 16, program memory entries.
- AW, 4, program address width; P <= 2^AW.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- prog_we  in  1  program write strobe.
- prog_addr  in  AW  program write address.
- prog_wdata  in  N+3  instruction word: [N+2:N] opcode, [N-1:0] operand.
- start  in  1  begin execution, single-cycle pulse.
- len  in  AW+1  number of instructions to run; sampled with `start`.
- e_out  out  3  opcode to stack machine `e_input`.
- g_out  out  N  operand to stack machine `g_input`.
- sm_rst  out  1  active-high clear to stack machine `rst`.
- sm_o  in  N  stack machine output `o`.
- busy  out  1  high in CLEAR, RUN and FINISH.
- done  out  1  run completed without error; sticky.
- err  out  1  run aborted; sticky.
- err_code  out  2  1 underflow, 2 overflow, 3 len>P.
- err_pc  out  AW  pc of the faulting instruction.
- result  out  N  signed final top-of-stack.

Behaviour:
- Opcode encoding:
  - 0 nop, 1 add, 2 sub, 3 mult, 4 push, 5 neg, 6 and, 7 or.
  - Class: push; unary = neg; binary = add, sub, mult, and, or; nop.
- Reset (rst_n low, asynchronous):
  - state=IDLE; pc, depth, result, err_code, err_pc = 0; done=err=0.
  - e_out=0, g_out=0.
  - sm_rst=1 while rst_n low (combinational OR with CLEAR state).
  - Program memory contents are not reset.
- Program writes:
  - Accepted only when busy=0: mem[prog_addr] <= prog_wdata on the clock edge.
  - Ignored while busy.
- IDLE:
  - Outputs e_out=0, g_out=0.
  - `start` sampled at edge t:
    - len>P: go ERR, err_code=3, err_pc=0.
    - Otherwise: latch len; clear done, err, depth, pc; go CLEAR.
  - `start` is ignored in every other state.
- CLEAR (one cycle, t+1):
  - sm_rst=1, e_out=0.
  - Next state is RUN, or FINISH if len==0.
- RUN (cycles t+2 .. t+1+len):
  - Combinational read of mem[pc]; e_out=opcode.
  - g_out=operand for push, else 0.
  - Pre-issue checks against current depth:
    - Binary with depth<2 -> underflow.
    - Unary with depth<1 -> underflow.
    - Push with depth==S -> overflow.
  - On a fault:
    - e_out forced to 0 that cycle.
    - err_code/err_pc latched, go ERR.
  - On a legal issue, depth update: push +1, binary -1, unary/nop unchanged.
  - pc increments; after pc==len-1 is issued, go FINISH.
- FINISH (one cycle):
  - e_out=0, so sm_o equals stack top.
  - result <= sm_o; done <= 1; go IDLE.
  - done asserted from cycle t+3+len.
- ERR:
  - err=1, e_out=0, result unchanged.
  - Return to IDLE next cycle; err stays sticky until next accepted start.
- Arithmetic:
  - Executed entirely by the stack machine; N-bit two's-complement wrap.
  - The sequencer never modifies operands.
- busy=1 exactly in CLEAR, RUN, FINISH.
- Reset mid-run:
  - Immediate abort, all state cleared.
  - sm_rst high, so the machine stack is cleared too.

Test Plan:
- Program [push 3, push 5, add], len=3, start at t -> e_out sequence 0,4,4,1,0; g_out 3,5 on the push cycles; result=8, done at t+6, err=0.
- [push 3, push 5, sub] -> result=2 (top minus second); [push 20, push 20, mult] -> result=-112 (400 wraps mod 256).
- [push 1, add] -> underflow at pc 1: err=1, err_code=1, err_pc=1, e_out=0 in the fault cycle, done=0.
- S=8 with nine pushes -> err_code=2, err_pc=8. len=17 -> err_code=3 with no sm_rst pulse. len=0 -> result=0, done at t+3.
- prog_we during RUN leaves memory unchanged on the next run. A start pulse during RUN is ignored.
- rst_n low mid-RUN -> outputs zero, sm_rst=1, state IDLE. A subsequent start runs correctly from pc 0.
